multi_lane_nonce_solver: RTL

- Parametrised successor of the single-lane solver. LANES parallel inner/outer SHA-256 pipelines search a job-supplied inclusive nonce range [nonce_start, nonce_end] for the double-SHA Bitcoin POW.
- Adds a job handshake, abort, and a valid/ready solution stream that can report one or all solutions.
- Sits between the job dispatcher and the result FIFO. Instantiates 2*LANES existing sha_core blocks: inner ones start from the midstate, outer ones from the SHA initial values.

---
 rtl/multi_lane_nonce_solver.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/multi_lane_nonce_solver.sv
// multi_lane_nonce_solver: LANES parallel double-SHA256 pipelines searching an inclusive nonce range
module sha_core (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_start,
   input  logic [255:0] i_init,
   input  logic [511:0] i_block,
   output logic         o_done,
   output logic [255:0] o_hash
);
   localparam logic [31:0] K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
   logic         r_busy;
   logic [5:0]   r_rnd;
   logic [511:0] r_w;
   logic [255:0] r_st, r_init;
   logic [31:0]  w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h, w_t1, w_t2, w_w16;
   logic [255:0] w_next, w_sum;
   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction
   assign {w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h} = r_st;
   assign w_t1 = w_h + (rotr(w_e, 6) ^ rotr(w_e, 11) ^ rotr(w_e, 25)) + ((w_e & w_f) ^ (~w_e & w_g)) + K[r_rnd] + r_w[511:480];
   assign w_t2 = (rotr(w_a, 2) ^ rotr(w_a, 13) ^ rotr(w_a, 22)) + ((w_a & w_b) ^ (w_a & w_c) ^ (w_b & w_c));
   assign w_next = {w_t1 + w_t2, w_a, w_b, w_c, w_d + w_t1, w_e, w_f, w_g};
   assign w_w16 = (rotr(r_w[63:32], 17) ^ rotr(r_w[63:32], 19) ^ (r_w[63:32] >> 10)) + r_w[223:192]
                + (rotr(r_w[479:448], 7) ^ rotr(r_w[479:448], 18) ^ (r_w[479:448] >> 3)) + r_w[511:480];
   // final digest: chaining value plus last round state, word by word
   always_comb begin
      w_sum = '0;
      for (int i = 0; i < 8; i++) w_sum[32*i +: 32] = r_init[32*i +: 32] + w_next[32*i +: 32];
   end
   // one compression round per cycle; a new start always restarts the core
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy <= 1'b0;
         r_rnd  <= '0;
         r_w    <= '0;
         r_st   <= '0;
         r_init <= '0;
         o_done <= 1'b0;
         o_hash <= '0;
      end else if (i_start) begin
         r_busy <= 1'b1;
         r_rnd  <= '0;
         r_w    <= i_block;
         r_st   <= i_init;
         r_init <= i_init;
         o_done <= 1'b0;
      end else begin
         o_done <= r_busy && r_rnd == 6'd63;
         if (r_busy) begin
            r_st  <= w_next;
            r_w   <= {r_w[479:0], w_w16};
            r_rnd <= r_rnd + 6'd1;
            if (r_rnd == 6'd63) begin
               r_busy <= 1'b0;
               o_hash <= w_sum;
            end
         end
      end
   end
endmodule

module multi_lane_nonce_solver #(
   parameter int LANES         = 4,
   parameter bit STOP_ON_FIRST = 1'b1,
   parameter int CNT_W         = 48
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             job_valid,
   output logic             job_ready,
   input  logic [255:0]     job_midstate,
   input  logic [95:0]      job_leftovers,
   input  logic [255:0]     job_target,
   input  logic [31:0]      job_nonce_start,
   input  logic [31:0]      job_nonce_end,
   input  logic             abort,
   output logic             sol_valid,
   input  logic             sol_ready,
   output logic [31:0]      sol_nonce,
   output logic [2:0]       status,
   output logic [CNT_W-1:0] hashes_done
);
   localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [2:0] S_IDLE = 3'd0, S_ISSUE = 3'd1, S_WAIT = 3'd2, S_REPORT = 3'd3,
                          S_FOUND = 3'd4, S_EXH = 3'd5, S_ABORT = 3'd6;
   localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
   logic [2:0]       r_state;
   logic [255:0]     r_mid, r_target;
   logic [95:0]      r_left;
   logic [31:0]      r_end, r_sol_nonce;
   logic [32:0]      r_base;
   logic [CNT_W-1:0] r_hashes;
   logic             r_sol_valid;
   logic [IW-1:0]    r_sel;
   logic [LANES-1:0] r_iss, r_ostart, r_idone, r_odone, r_in_valid, r_out_valid, r_pend;
   logic [31:0]      r_iss_nonce [LANES], r_in_nonce [LANES], r_out_nonce [LANES];
   logic [255:0]     r_in_hash [LANES], r_out_hash [LANES];
   logic [32:0]      w_n [LANES];
   logic [255:0]     w_ihash [LANES], w_ohash [LANES];
   logic [LANES-1:0] w_iss, w_istart, w_ostart, w_idone, w_odone, w_hit, w_act;
   logic [IW-1:0]    w_first;
   logic [CNT_W-1:0] w_cnt;
   logic             w_step_done;
   function automatic logic [255:0] bswap256(input logic [255:0] x);
      for (int i = 0; i < 32; i++) bswap256[8*i +: 8] = x[255-8*i -: 8];
   endfunction
   assign job_ready   = r_state == S_IDLE;
   assign status      = r_state;
   assign sol_valid   = r_sol_valid;
   assign sol_nonce   = r_sol_nonce;
   assign hashes_done = r_hashes;
   assign w_act       = w_hit & r_pend;
   assign w_step_done = &((r_idone | w_idone | ~r_iss) & (r_odone | w_odone | ~r_ostart));
   for (genvar k = 0; k < LANES; k++) begin : g_lane
      // the 33rd bit catches lanes that would run past 0xFFFFFFFF
      assign w_n[k]      = r_base + 33'(k);
      assign w_iss[k]    = !w_n[k][32] && w_n[k][31:0] <= r_end;
      assign w_istart[k] = r_state == S_ISSUE && w_iss[k];
      assign w_ostart[k] = r_state == S_ISSUE && r_in_valid[k];
      assign w_hit[k]    = r_out_valid[k] && bswap256(r_out_hash[k]) < r_target;
      // header stores the nonce little-endian
      sha_core u_inner (
         .clk     (clk),
         .rst_n   (rst_n),
         .i_start (w_istart[k]),
         .i_init  (r_mid),
         .i_block ({r_left, w_n[k][7:0], w_n[k][15:8], w_n[k][23:16], w_n[k][31:24], 8'h80, 360'b0, 16'h0280}),
         .o_done  (w_idone[k]),
         .o_hash  (w_ihash[k])
      );
      sha_core u_outer (
         .clk     (clk),
         .rst_n   (rst_n),
         .i_start (w_ostart[k]),
         .i_init  (IV),
         .i_block ({r_in_hash[k], 8'h80, 232'b0, 16'h0100}),
         .o_done  (w_odone[k]),
         .o_hash  (w_ohash[k])
      );
   end
   // count valid outer results and pick the lowest pending hit
   always_comb begin
      w_cnt   = '0;
      w_first = '0;
      for (int i = LANES - 1; i >= 0; i--) begin
         w_cnt = w_cnt + CNT_W'(r_in_valid[i]);
         if (w_act[i]) w_first = IW'(i);
      end
   end
   // job control, two-stage lane pipeline and solution stream
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_mid       <= '0;
         r_target    <= '0;
         r_left      <= '0;
         r_end       <= '0;
         r_base      <= '0;
         r_hashes    <= '0;
         r_sol_valid <= 1'b0;
         r_sol_nonce <= '0;
         r_sel       <= '0;
         r_iss       <= '0;
         r_ostart    <= '0;
         r_idone     <= '0;
         r_odone     <= '0;
         r_in_valid  <= '0;
         r_out_valid <= '0;
         r_pend      <= '0;
         for (int i = 0; i < LANES; i++) begin
            r_iss_nonce[i] <= '0;
            r_in_nonce[i]  <= '0;
            r_out_nonce[i] <= '0;
            r_in_hash[i]   <= '0;
            r_out_hash[i]  <= '0;
         end
      end else begin
         r_idone <= r_idone | w_idone;
         r_odone <= r_odone | w_odone;
         case (r_state)
            S_IDLE: if (job_valid) begin
               r_mid       <= job_midstate;
               r_left      <= job_leftovers;
               r_target    <= job_target;
               r_end       <= job_nonce_end;
               r_base      <= {1'b0, job_nonce_start};
               r_hashes    <= '0;
               r_in_valid  <= '0;
               r_out_valid <= '0;
               r_state     <= job_nonce_start > job_nonce_end ? S_EXH : S_ISSUE;
            end
            S_ISSUE: if (abort) begin
               r_in_valid  <= '0;
               r_out_valid <= '0;
               r_state     <= S_ABORT;
            end else begin
               r_iss    <= w_iss;
               r_ostart <= r_in_valid;
               r_idone  <= '0;
               r_odone  <= '0;
               for (int i = 0; i < LANES; i++) r_iss_nonce[i] <= w_n[i][31:0];
               r_state  <= (|w_iss || |r_in_valid) ? S_WAIT : S_EXH;
            end
            S_WAIT: if (abort) begin
               r_in_valid  <= '0;
               r_out_valid <= '0;
               r_state     <= S_ABORT;
            end else if (w_step_done) begin
               for (int i = 0; i < LANES; i++) begin
                  r_out_hash[i]  <= w_ohash[i];
                  r_out_nonce[i] <= r_in_nonce[i];
                  r_in_hash[i]   <= w_ihash[i];
                  r_in_nonce[i]  <= r_iss_nonce[i];
               end
               r_out_valid <= r_in_valid;
               r_in_valid  <= r_iss;
               r_hashes    <= r_hashes + w_cnt;
               r_base      <= r_base + 33'(LANES);
               r_pend      <= '1;
               r_state     <= S_REPORT;
            end
            S_REPORT: if (abort) begin
               r_sol_valid <= 1'b0;
               r_in_valid  <= '0;
               r_out_valid <= '0;
               r_state     <= S_ABORT;
            end else if (r_sol_valid) begin
               if (sol_ready) begin
                  r_sol_valid   <= 1'b0;
                  r_pend[r_sel] <= 1'b0;
                  if (STOP_ON_FIRST) r_state <= S_FOUND;
               end
            end else if (|w_act) begin
               r_sol_valid <= 1'b1;
               r_sol_nonce <= r_out_nonce[w_first];
               r_sel       <= w_first;
            end else begin
               r_state <= S_ISSUE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule
